// File: rtl/sram_arb.sv
// Round-robin arbiter giving two requesters shared access to a single-port SRAM,
// with a self-timed sweep that writes INIT_VAL to every word.
module sram_arb #(
    parameter logic [7:0] INIT_VAL = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [9:0] addr0,
    input  logic [9:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata,
    input  logic       init_start,
    output logic       init_busy,
    output logic       init_done,
    input  logic [7:0] sram_q,
    output logic [9:0] sram_a,
    output logic [7:0] sram_d,
    output logic       sram_wen
);

    typedef enum logic {StArb = 1'b0, StClear = 1'b1} state_t;

    state_t     r_state;
    logic [9:0] r_cnt;
    logic       r_last;
    logic [9:0] r_sram_a;
    logic [7:0] r_sram_d;
    logic       r_sram_wen;
    logic       r_rd0;
    logic       r_rd1;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic       r_init_done;
    logic       w_arb;
    logic       w_gnt0;
    logic       w_gnt1;

    assign w_arb = (r_state == StArb) && !reset;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_arb) begin
            if (req0 && req1) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StArb;
            r_cnt       <= 10'd0;
            r_last      <= 1'b1;
            r_sram_a    <= 10'd0;
            r_sram_d    <= 8'd0;
            r_sram_wen  <= 1'b0;
            r_rd0       <= 1'b0;
            r_rd1       <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            // Read pipeline: SRAM sees the address in t+1, data is valid in t+2.
            r_rd0       <= w_gnt0 && !we0;
            r_rd1       <= w_gnt1 && !we1;
            r_rvalid0   <= r_rd0;
            r_rvalid1   <= r_rd1;
            r_init_done <= 1'b0;
            r_sram_wen  <= 1'b0;
            case (r_state)
                StArb: begin
                    if (w_gnt0) begin
                        r_sram_a   <= addr0;
                        r_sram_d   <= wdata0;
                        r_sram_wen <= we0;
                        r_last     <= 1'b0;
                    end else if (w_gnt1) begin
                        r_sram_a   <= addr1;
                        r_sram_d   <= wdata1;
                        r_sram_wen <= we1;
                        r_last     <= 1'b1;
                    end
                    if (init_start) begin
                        r_state <= StClear;
                    end
                end
                StClear: begin
                    r_sram_a   <= r_cnt;
                    r_sram_d   <= INIT_VAL;
                    r_sram_wen <= 1'b1;
                    r_cnt      <= r_cnt + 10'd1;
                    if (r_cnt == 10'd1023) begin
                        r_state     <= StArb;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= StArb;
            endcase
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata     = sram_q;
    assign init_busy = (r_state == StClear);
    assign init_done = r_init_done;
    assign sram_a    = r_sram_a;
    assign sram_d    = r_sram_d;
    assign sram_wen  = r_sram_wen;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: behavioural SRAM, transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_sram_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [9:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       init_start, init_busy, init_done;
    logic [7:0] sram_q;
    logic [9:0] sram_a;
    logic [7:0] sram_d;
    logic       sram_wen;

    int total = 0;
    int bad   = 0;

    sram_arb #(.INIT_VAL(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .sram_q     (sram_q),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_wen   (sram_wen)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        int v;
        v = i * 7 + 3;
        return v[7:0];
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, want);
        end
    endtask

    // Synchronous single-port SRAM: read-before-write, data out one cycle later.
    logic [7:0] mem [0:1023];
    bit         mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = pat(i);
            mem_init = 1'b1;
        end
        sram_q = mem[sram_a];
        if (sram_wen) mem[sram_a] = sram_d;
    end

    // Reference model: grants from request rules, accesses as a one-deep op,
    // read results scheduled by cycle number.
    logic [7:0] ref_mem [0:1023];
    bit         m_init = 1'b0;
    bit         m_clear;
    int         m_idx;
    int         m_last_win;
    bit         m_done;
    bit         op_v, op_we;
    int         op_req;
    logic [9:0] op_a, h_a;
    logic [7:0] op_d, h_d;
    logic [7:0] rv0_dat [int];
    logic [7:0] rv1_dat [int];
    int         cyc = 0;

    always @(negedge clk) begin
        bit eg0, eg1;
        int win;
        if (!m_init) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
            m_init = 1'b1;
        end
        cyc++;
        if (reset) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_a", sram_a, 0);
            chk("rst_d", sram_d, 0);
            chk("rst_wen", sram_wen, 0);
            chk("rst_rv0", rvalid0, 0);
            chk("rst_rv1", rvalid1, 0);
            chk("rst_busy", init_busy, 0);
            chk("rst_done", init_done, 0);
            m_clear = 0; m_idx = 0; m_last_win = 1; m_done = 0; op_v = 0;
            h_a = '0; h_d = '0;
            rv0_dat.delete();
            rv1_dat.delete();
        end else begin
            if (op_v) begin
                h_a = op_a;
                h_d = op_d;
            end
            chk("port_wen", sram_wen, int'(op_v && op_we));
            chk("port_a", sram_a, h_a);
            chk("port_d", sram_d, h_d);
            if (op_v && op_we) ref_mem[op_a] = op_d;
            if (op_v && !op_we) begin
                if (op_req == 1) rv1_dat[cyc + 1] = ref_mem[op_a];
                else             rv0_dat[cyc + 1] = ref_mem[op_a];
            end
            chk("rvalid0", rvalid0, int'(rv0_dat.exists(cyc)));
            chk("rvalid1", rvalid1, int'(rv1_dat.exists(cyc)));
            if (rv0_dat.exists(cyc)) begin
                chk("rdata0", rdata, rv0_dat[cyc]);
                rv0_dat.delete(cyc);
            end
            if (rv1_dat.exists(cyc)) begin
                chk("rdata1", rdata, rv1_dat[cyc]);
                rv1_dat.delete(cyc);
            end
            chk("busy", init_busy, int'(m_clear));
            chk("done", init_done, int'(m_done));
            eg0 = 0; eg1 = 0;
            if (!m_clear) begin
                if (req0 && req1) begin
                    win = (m_last_win == 0) ? 1 : 0;
                    eg0 = (win == 0);
                    eg1 = (win == 1);
                end else begin
                    eg0 = req0;
                    eg1 = req1;
                end
            end
            chk("gnt0", gnt0, int'(eg0));
            chk("gnt1", gnt1, int'(eg1));
            op_v = 0;
            m_done = 0;
            if (m_clear) begin
                op_v = 1; op_we = 1; op_a = m_idx[9:0]; op_d = 8'h00;
                m_idx++;
                if (m_idx == 1024) begin
                    m_clear = 0; m_idx = 0; m_done = 1;
                end
            end else begin
                if (eg0) begin
                    op_v = 1; op_we = we0; op_a = addr0; op_d = wdata0; op_req = 0; m_last_win = 0;
                end else if (eg1) begin
                    op_v = 1; op_we = we1; op_a = addr1; op_d = wdata1; op_req = 1; m_last_win = 1;
                end
                if (init_start) m_clear = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd0(input logic [9:0] a, input logic [7:0] e, input string nm);
        req0 = 1; we0 = 0; addr0 = a;
        @(negedge clk);
        chk({nm, "_gnt"}, gnt0, 1);
        step();
        req0 = 0;
        step();
        @(negedge clk);
        chk({nm, "_rv"}, rvalid0, 1);
        chk({nm, "_dat"}, rdata, e);
        step();
    endtask

    int         t_r  [5] = '{0, 1, 0, 1, 0};
    bit         t_we [5] = '{1, 0, 0, 1, 0};
    logic [9:0] t_a  [5] = '{10'd20, 10'd20, 10'd20, 10'd21, 10'd21};
    logic [7:0] t_d  [5] = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h00};

    initial begin
        int busy_cnt, wr_cnt, exp_addr, gnt_leak;
        bit found, seen_done;
        reset = 1; req0 = 1; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; init_start = 0;
        repeat (3) step();
        @(negedge clk);
        chk("L_rst_gnt0", gnt0, 0);
        chk("L_rst_wen", sram_wen, 0);
        chk("L_rst_busy", init_busy, 0);
        step();
        reset = 0; req0 = 0;

        // Single write
        req0 = 1; we0 = 1; addr0 = 10'd5; wdata0 = 8'hA3;
        @(negedge clk);
        chk("L_w_gnt0", gnt0, 1);
        step();
        req0 = 0; we0 = 0;
        @(negedge clk);
        chk("L_w_a", sram_a, 5);
        chk("L_w_d", sram_d, 8'hA3);
        chk("L_w_wen", sram_wen, 1);
        step();
        @(negedge clk);
        chk("L_w_wen_off", sram_wen, 0);

        // Read-back by requester 1
        step();
        req1 = 1; we1 = 0; addr1 = 10'd5;
        @(negedge clk);
        chk("L_r_gnt1", gnt1, 1);
        step();
        req1 = 0;
        @(negedge clk);
        chk("L_r_rv_early", rvalid1, 0);
        step();
        @(negedge clk);
        chk("L_r_rv", rvalid1, 1);
        chk("L_r_dat", rdata, 8'hA3);

        // Back-to-back mixed accesses
        step();
        for (int i = 0; i < 5; i++) begin
            req0 = (t_r[i] == 0); req1 = (t_r[i] == 1);
            we0 = t_we[i]; we1 = t_we[i];
            addr0 = t_a[i]; addr1 = t_a[i];
            wdata0 = t_d[i]; wdata1 = t_d[i];
            @(negedge clk);
            chk("L_b2b_gnt", (t_r[i] == 0) ? gnt0 : gnt1, 1);
            if (i == 3) begin
                chk("L_b2b_rv1", rvalid1, 1);
                chk("L_b2b_dat1", rdata, 8'h11);
            end
            if (i == 4) begin
                chk("L_b2b_rv0", rvalid0, 1);
                chk("L_b2b_dat0", rdata, 8'h11);
            end
            step();
        end
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        repeat (3) step();

        // Contention right after reset: 0,1,0,1
        reset = 1;
        step();
        reset = 0;
        req0 = 1; req1 = 1; addr0 = 10'd7; addr1 = 10'd9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("L_rr_gnt0", gnt0, int'(k % 2 == 0));
            chk("L_rr_gnt1", gnt1, int'(k % 2 == 1));
            step();
        end
        req0 = 0; req1 = 0;
        repeat (3) step();

        // Reset one cycle after a read grant flushes its rvalid
        req0 = 1; we0 = 0; addr0 = 10'd5;
        @(negedge clk);
        chk("L_rf_gnt0", gnt0, 1);
        step();
        req0 = 0; reset = 1;
        step();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("L_rf_rv0", rvalid0, 0);
            step();
        end

        // Reset mid-sweep after the write to address 300
        req1 = 1; we1 = 1; addr1 = 10'd301; wdata1 = 8'h5C;
        step();
        addr1 = 10'd1023; wdata1 = 8'hE7;
        step();
        req1 = 0; we1 = 0; init_start = 1;
        step();
        init_start = 0;
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (sram_wen && sram_a == 10'd300) found = 1;
            step();
        end
        chk("L_ab_found300", int'(found), 1);
        reset = 1;
        @(negedge clk);
        chk("L_ab_busy", init_busy, 0);
        chk("L_ab_wen", sram_wen, 0);
        chk("L_ab_a", sram_a, 0);
        chk("L_ab_done", init_done, 0);
        step();
        reset = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("L_ab_nodone", init_done, 0);
            chk("L_ab_idle", init_busy, 0);
            step();
        end
        rd0(10'd300, 8'h00, "L_ab_300");
        rd0(10'd299, 8'h00, "L_ab_299");
        rd0(10'd301, 8'h5C, "L_ab_301");
        rd0(10'd1023, 8'hE7, "L_ab_1023");

        // Full sweep with a read granted alongside init_start and req0 held
        init_start = 1; req1 = 1; we1 = 0; addr1 = 10'd1000;
        @(negedge clk);
        chk("L_sw_gnt1", gnt1, 1);
        step();
        init_start = 0; req1 = 0;
        req0 = 1; we0 = 0; addr0 = 10'd3;
        busy_cnt = 0; wr_cnt = 0; exp_addr = 0; gnt_leak = 0; seen_done = 0;
        for (int k = 0; k < 1100 && !seen_done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("L_sw_rv1", rvalid1, 1);
                chk("L_sw_dat1", rdata, pat(1000));
            end
            if (sram_wen && sram_a == exp_addr[9:0] && sram_d == 8'h00) begin
                wr_cnt++;
                exp_addr++;
            end
            if (init_busy) begin
                busy_cnt++;
                if (gnt0 || init_done) gnt_leak++;
            end else begin
                seen_done = 1;
                chk("L_sw_done", init_done, 1);
                chk("L_sw_gnt0", gnt0, 1);
            end
            step();
            init_start = (busy_cnt == 500);
        end
        init_start = 0;
        req0 = 0;
        chk("L_sw_seen_done", int'(seen_done), 1);
        chk("L_sw_busy_cnt", busy_cnt, 1024);
        chk("L_sw_wr_cnt", wr_cnt, 1024);
        chk("L_sw_leak", gnt_leak, 0);
        step();
        @(negedge clk);
        chk("L_sw_rv0", rvalid0, 1);
        chk("L_sw_dat0", rdata, 8'h00);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter INIT_VAL, default 8'd0, the value written to every SRAM word during a clear sweep.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  access request from requester 0 (labeler) and requester 1 (reader).
REQ-005 SHALL have ports we0/we1  input  1  1 = write, 0 = read; qualified by reqN.
REQ-006 SHALL have ports addr0/addr1  input  10  word address 0..1023.
REQ-007 SHALL have ports wdata0/wdata1  input  8  write data.
REQ-008 SHALL have ports gnt0/gnt1  output  1  combinational grant; the access is accepted at the next rising edge.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1  read data valid on rdata for that requester.
REQ-010 SHALL have port rdata  output  8  equals sram_q, passed through combinationally.
REQ-011 SHALL have port init_start  input  1  one-cycle pulse that starts a clear sweep.
REQ-012 SHALL have port init_busy  output  1  high while a sweep is in progress.
REQ-013 SHALL have port init_done  output  1  one-cycle pulse when a sweep completes.
REQ-014 SHALL have ports sram_q  input  8, sram_a  output  10, sram_d  output  8, sram_wen  output  1  single-port SRAM; sram_wen=1 means write.

Function
REQ-015 SHALL implement states ARB and CLEAR; reset enters ARB.
REQ-016 ARB: SHALL assert at most one gntN per cycle, and only when the corresponding reqN=1.
REQ-017 ARB, one request: SHALL grant it in the same cycle.
REQ-018 ARB, both requesting: SHALL grant the requester not served by the most recent grant (round-robin); the last-winner register resets to 1, so requester 0 wins the first tie.
REQ-019 SHALL load the winner's addr into sram_a, wdata into sram_d and we into sram_wen at the edge ending the grant cycle t; these drive the SRAM during cycle t+1.
REQ-020 In any cycle with no access, SHALL drive sram_wen=0 while sram_a and sram_d hold their previous values.
REQ-021 Read granted in cycle t: SHALL assert rvalidN for exactly cycle t+2, when rdata=sram_q holds the data at addr.
REQ-022 Requester obligation: req/we/addr/wdata held stable until gnt is seen; a requester may re-request in the cycle after its grant.
REQ-023 Back-to-back accesses SHALL be supported: one access per cycle, and rvalid pipelines for the two requesters are independent.
REQ-024 In ARB, init_start=1 SHALL move to CLEAR at the next edge; any request granted in that same cycle still completes.
REQ-025 CLEAR: SHALL issue writes of INIT_VAL to addresses 0,1,...,1023, one per cycle, using a 10-bit counter.
REQ-026 CLEAR: gnt0=gnt1=0 and init_busy=1, from the first CLEAR cycle through the cycle issuing address 1023.
REQ-027 Counter wrap: after the write to address 1023 is issued, SHALL return to ARB, pulse init_done for exactly one cycle and reset the counter to 0.
REQ-028 init_start during CLEAR SHALL be ignored, with no restart.
REQ-029 rvalid for reads issued before CLEAR SHALL still assert on schedule during CLEAR.
REQ-030 Pending requests SHALL be arbitrated normally starting from the cycle init_done is high.
REQ-031 A sweep SHALL take 1024 cycles from the first CLEAR cycle to init_done.

Reset
REQ-032 reset=1 SHALL immediately force: sram_a=0, sram_d=0, sram_wen=0, gnt0=gnt1=0, rvalid0=rvalid1=0, init_busy=0, init_done=0, state ARB, clear counter 0, last-winner 1.
REQ-033 Reset mid-sweep SHALL abort the sweep with no init_done pulse; a new init_start is required to clear again.
REQ-034 Reset SHALL flush any in-flight rvalid.

Verification
REQ-035 Single write: req0=1, we0=1, addr0=10'd5, wdata0=8'hA3 -> gnt0=1 in cycle t; in cycle t+1 sram_a=5, sram_d=A3, sram_wen=1; in cycle t+2 sram_wen=0.
REQ-036 Read-back: after REQ-035, req1 reads addr 5 -> rvalid1=1 with rdata=8'hA3 exactly two cycles after gnt1.
REQ-037 Contention: req0 and req1 held high for 4 cycles after reset -> grants follow 0,1,0,1 with no idle cycle.
REQ-038 Clear sweep: init_start pulse with req0 held -> init_busy high for 1024 cycles, gnt0 stays low, 1024 writes of 8'h00 to addresses 0..1023 in order, then one init_done pulse and gnt0=1 in that same cycle.
REQ-039 Reset after the write to address 300 of a sweep -> all outputs take their REQ-032 values, no init_done, and a later read returns the pre-sweep contents above address 300.
REQ-040 Reset during a read: reset asserted at cycle t+1 after a read grant -> rvalid never asserts.
